// File: rtl/inst_queue.sv
// Circular instruction/PC FIFO between fetch and issue; the head entry drives the issue stage.
// Optional stall/flush statistics counters are built only when INST_QUEUE_STATS_EN is defined.
module inst_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [31:0]            push_pc,
  input  logic [31:0]            push_inst,
  input  logic                   pop,
  input  logic                   flush,
  output logic                   full,
  output logic                   valid,
  output logic [31:0]            IR_ID,
  output logic [31:0]            PCurrent_ID,
  output logic [$clog2(DEPTH):0] count,
  output logic [15:0]            stat_full_cycles,
  output logic [15:0]            stat_flushes
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               pop_eff;
  logic               push_acc;
  entry_t             head;

  // Status comes only from the registered count, never from this cycle's controls.
  assign valid = (count_q != '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign count = count_q;

  assign pop_eff  = pop & valid & ~flush;
  assign push_acc = push & ~flush & (~full | pop_eff);

  assign head        = mem_q[rd_ptr_q];
  assign IR_ID       = valid ? head.inst : NOP_INST;
  assign PCurrent_ID = valid ? head.pc   : 32'h0;

  // Pointer/count next state; flush discards everything including this cycle's push/pop.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (pop_eff)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push_acc) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      unique case ({push_acc, pop_eff})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately not reset; only pointers and count define occupancy.
  always_ff @(posedge clk) begin
    if (push_acc) begin
      mem_q[wr_ptr_q] <= '{pc: push_pc, inst: push_inst};
    end
  end

`ifdef INST_QUEUE_STATS_EN
  logic [15:0] full_cyc_q, full_cyc_d;
  logic [15:0] flushes_q, flushes_d;

  // Saturating counters, cleared only by reset.
  always_comb begin
    full_cyc_d = full_cyc_q;
    flushes_d  = flushes_q;
    if (full & ~pop & ~flush && full_cyc_q != 16'hFFFF) full_cyc_d = full_cyc_q + 16'd1;
    if (flush && flushes_q != 16'hFFFF)                 flushes_d  = flushes_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_cyc_q <= '0;
      flushes_q  <= '0;
    end else begin
      full_cyc_q <= full_cyc_d;
      flushes_q  <= flushes_d;
    end
  end

  assign stat_full_cycles = full_cyc_q;
  assign stat_flushes     = flushes_q;
`else
  assign stat_full_cycles = 16'h0000;
  assign stat_flushes     = 16'h0000;
`endif

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: queue-based reference model plus directed vectors.
// Stat expectations follow INST_QUEUE_STATS_EN when it is defined for the build.
module tb_inst_queue;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        push = 1'b0, pop = 1'b0, flush = 1'b0;
  logic [31:0] push_pc = '0, push_inst = '0;
  logic        full, valid;
  logic [31:0] IR_ID, PCurrent_ID;
  logic [$clog2(DEPTH):0] count;
  logic [15:0] stat_full_cycles, stat_flushes;

  int tests = 0;
  int fails = 0;
  bit started = 1'b0;

  // Reference model state
  logic [63:0] mq[$];
  int unsigned m_full_cyc = 0;
  int unsigned m_flushes  = 0;

  inst_queue #(.DEPTH(DEPTH), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst), .push(push), .push_pc(push_pc), .push_inst(push_inst),
    .pop(pop), .flush(flush), .full(full), .valid(valid), .IR_ID(IR_ID),
    .PCurrent_ID(PCurrent_ID), .count(count),
    .stat_full_cycles(stat_full_cycles), .stat_flushes(stat_flushes)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ins(input logic [31:0] pc);
    return pc ^ 32'hA500_0033;
  endfunction

  // Model: FIFO semantics from the operating rules, updated on each edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_full_cyc = 0;
      m_flushes  = 0;
    end else begin
      bit pe, acc;
      pe  = pop && (mq.size() > 0) && !flush;
      acc = push && !flush && ((mq.size() < DEPTH) || pe);
      if (mq.size() == DEPTH && !pop && !flush && m_full_cyc < 16'hFFFF) m_full_cyc++;
      if (flush && m_flushes < 16'hFFFF) m_flushes++;
      if (push && !flush && !acc)
        $display("[TB] note: push while full without pop dropped (t=%0t)", $time);
      if (flush) mq.delete();
      else begin
        if (pe)  void'(mq.pop_front());
        if (acc) mq.push_back({push_pc, push_inst});
      end
    end
  end

  // Continuous compare against the model on every falling edge out of reset.
  always @(negedge clk) begin
    if (started && !rst) begin
      logic [31:0] e_ir, e_pc;
      e_ir = (mq.size() > 0) ? mq[0][31:0]  : NOP;
      e_pc = (mq.size() > 0) ? mq[0][63:32] : 32'h0;
      chk("cmp_count", 32'(count), 32'(mq.size()));
      chk("cmp_valid", 32'(valid), 32'(mq.size() != 0));
      chk("cmp_full",  32'(full),  32'(mq.size() == DEPTH));
      chk("cmp_ir",    IR_ID, e_ir);
      chk("cmp_pc",    PCurrent_ID, e_pc);
`ifdef INST_QUEUE_STATS_EN
      chk("cmp_stat_full",  32'(stat_full_cycles), m_full_cyc);
      chk("cmp_stat_flush", 32'(stat_flushes),     m_flushes);
`else
      chk("cmp_stat_full",  32'(stat_full_cycles), 32'h0);
      chk("cmp_stat_flush", 32'(stat_flushes),     32'h0);
`endif
    end
  end

  // Drive one cycle's inputs just after a falling edge and wait for the next falling edge.
  task automatic cyc(input logic p, input logic [31:0] pc, input logic [31:0] inst,
                     input logic po, input logic fl);
    push = p; push_pc = pc; push_inst = inst; pop = po; flush = fl;
    @(negedge clk);
    push = 1'b0; pop = 1'b0; flush = 1'b0;
  endtask

  task automatic pushc(input logic [31:0] pc);
    cyc(1'b1, pc, ins(pc), 1'b0, 1'b0);
  endtask

  task automatic popc();
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    started = 1'b1;

    // Reset state
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_full",  32'(full),  32'h0);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_ir",    IR_ID, 32'h0000_0013);
    chk("rst_pc",    PCurrent_ID, 32'h0);

    // Single push, one-cycle latency
    cyc(1'b1, 32'h0, 32'h0050_0093, 1'b0, 1'b0);
    chk("t1_valid", 32'(valid), 32'h1);
    chk("t1_ir",    IR_ID, 32'h0050_0093);
    chk("t1_pc",    PCurrent_ID, 32'h0);
    chk("t1_count", 32'(count), 32'h1);
    popc();
    chk("t1_empty", 32'(valid), 32'h0);

    // Fill, drop a 5th push, drain in order
    pushc(32'h0); pushc(32'h4); pushc(32'h8); pushc(32'hC);
    chk("t2_full",  32'(full),  32'h1);
    chk("t2_count", 32'(count), 32'h4);
    pushc(32'h14);
    chk("t2_drop_count", 32'(count), 32'h4);
    chk("t2_head0", PCurrent_ID, 32'h0);
    chk("t2_inst0", IR_ID, ins(32'h0));
    popc(); chk("t2_head1", PCurrent_ID, 32'h4);
    popc(); chk("t2_head2", PCurrent_ID, 32'h8);
    popc(); chk("t2_head3", PCurrent_ID, 32'hC);
    popc();
    chk("t2_valid", 32'(valid), 32'h0);
    chk("t2_nop",   IR_ID, 32'h0000_0013);

    // Push+pop while full, wrap
    pushc(32'h0); pushc(32'h4); pushc(32'h8); pushc(32'hC);
    cyc(1'b1, 32'h10, ins(32'h10), 1'b1, 1'b0);
    chk("t3_count", 32'(count), 32'h4);
    chk("t3_full",  32'(full),  32'h1);
    chk("t3_head",  PCurrent_ID, 32'h4);
    popc(); popc(); popc();
    chk("t3_wrap_head", PCurrent_ID, 32'h10);
    chk("t3_wrap_inst", IR_ID, ins(32'h10));
    popc();
    chk("t3_empty", 32'(count), 32'h0);

    // Push+pop while empty
    cyc(1'b1, 32'h30, ins(32'h30), 1'b1, 1'b0);
    chk("t3e_count", 32'(count), 32'h1);
    chk("t3e_head",  PCurrent_ID, 32'h30);
    popc();

    // Flush with simultaneous push and pop
    pushc(32'h20); pushc(32'h24); pushc(32'h28);
    cyc(1'b1, 32'h40, ins(32'h40), 1'b1, 1'b1);
    chk("t4_count", 32'(count), 32'h0);
    chk("t4_valid", 32'(valid), 32'h0);
    chk("t4_ir",    IR_ID, 32'h0000_0013);
    pushc(32'h80);
    chk("t4_head",  PCurrent_ID, 32'h80);
    chk("t4_valid2", 32'(valid), 32'h1);

    // Async reset between edges with two entries
    pushc(32'h84);
    chk("t5_count", 32'(count), 32'h2);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_valid", 32'(valid), 32'h0);
    chk("t5_rst_count", 32'(count), 32'h0);
    chk("t5_rst_full",  32'(full),  32'h0);
    chk("t5_rst_ir",    IR_ID, 32'h0000_0013);
    chk("t5_rst_pc",    PCurrent_ID, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    pushc(32'h200);
    chk("t5_head", PCurrent_ID, 32'h200);
    chk("t5_inst", IR_ID, ins(32'h200));
    popc();

    // Statistics: 5 full-without-pop cycles, then two flushes
    pushc(32'h0); pushc(32'h4); pushc(32'h8); pushc(32'hC);
    repeat (5) cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
`ifdef INST_QUEUE_STATS_EN
    chk("t6_stat_full",  32'(stat_full_cycles), 32'd5);
    chk("t6_stat_flush", 32'(stat_flushes),     32'd2);
`else
    chk("t6_stat_full",  32'(stat_full_cycles), 32'd0);
    chk("t6_stat_flush", 32'(stat_flushes),     32'd0);
`endif
    chk("t6_valid", 32'(valid), 32'h0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
